// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling and framing-error detection.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN, which
// adds the PARITY state and the UART_ERR_PAR output.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       UART_RXD,
  output logic [7:0] UART_RxREG,
  output logic       UART_STA_RX,
  output logic       UART_ERR_FRM,
  output logic       UART_BUSY
`ifdef UART_RX_PARITY_EN
  ,
  output logic       UART_ERR_PAR
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK_WAIT
`ifdef UART_RX_PARITY_EN
    ,
    PARITY
`endif
  } state_t;

  state_t        state;
  logic          sync1;
  logic          rxs;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
`ifdef UART_RX_PARITY_EN
  logic          par_ok;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= UART_RXD;
      rxs   <= sync1;
    end
  end

  // Frame FSM: all outputs are registered, strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      UART_RxREG   <= 8'h00;
      UART_STA_RX  <= 1'b0;
      UART_ERR_FRM <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok       <= 1'b1;
      UART_ERR_PAR <= 1'b0;
`endif
    end else begin
      UART_STA_RX  <= 1'b0;
      UART_ERR_FRM <= 1'b0;
`ifdef UART_RX_PARITY_EN
      UART_ERR_PAR <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rxs) begin
            clk_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          // Half a bit in: confirm the start bit is still low, else it was a glitch.
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            par_ok  <= ~(^{shreg, rxs});
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
`endif
        STOP: begin
          // Returning to IDLE at mid-stop keeps back-to-back start edges visible.
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            if (!rxs) begin
              UART_ERR_FRM <= 1'b1;
              state        <= BRK_WAIT;
            end else begin
              state <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_ok) begin
                UART_RxREG  <= shreg;
                UART_STA_RX <= 1'b1;
              end else begin
                UART_ERR_PAR <= 1'b1;
              end
`else
              UART_RxREG  <= shreg;
              UART_STA_RX <= 1'b1;
`endif
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        BRK_WAIT: begin
          // A held-low line yields one error; wait for it to release.
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign UART_BUSY = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized + directed frames against a scoreboard of expected
// receive events (good byte / framing error / parity error) with arrival time.
module tb_uart_rx;

  localparam int N   = 16;
  localparam int HALF = N / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Start edge to strobe: 2 sync cycles + half bit + remaining bits to mid-stop.
  localparam int EXP_LAT = 2 + HALF + (9 + PB) * N;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       UART_RXD = 1'b1;
  logic [7:0] UART_RxREG;
  logic       UART_STA_RX;
  logic       UART_ERR_FRM;
  logic       UART_BUSY;
  logic       par_pulse;
`ifdef UART_RX_PARITY_EN
  logic       UART_ERR_PAR;
  assign par_pulse = UART_ERR_PAR;
`else
  assign par_pulse = 1'b0;
`endif

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .UART_RXD     (UART_RXD),
    .UART_RxREG   (UART_RxREG),
    .UART_STA_RX  (UART_STA_RX),
    .UART_ERR_FRM (UART_ERR_FRM),
    .UART_BUSY    (UART_BUSY)
`ifdef UART_RX_PARITY_EN
    ,
    .UART_ERR_PAR (UART_ERR_PAR)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 good byte, 1 framing error, 2 parity error
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         c0;
  } exp_t;

  exp_t       sb[$];
  int         n_vec  = 0;
  int         n_miss = 0;
  logic [7:0] model_reg = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int cycles);
    UART_RXD = b;
    tick(cycles);
  endtask

  // Whole frame; stop_low>0 holds the stop bit low for that many bit times.
  task automatic send_frame(input logic [7:0] d, input logic par, input int stop_low);
    exp_t e;
    e.data = d;
    e.c0   = cyc;
    if (stop_low > 0)            e.kind = 1;
    else if (PB == 1 && ((^d) ^ par)) e.kind = 2;
    else                         e.kind = 0;
    sb.push_back(e);
    drive_bit(1'b0, N);
    for (int i = 0; i < 8; i++) drive_bit(d[i], N);
    if (PB == 1) drive_bit(par, N);
    if (stop_low > 0) drive_bit(1'b0, stop_low * N);
    drive_bit(1'b1, N);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 4000) begin
      tick(1);
      i++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: %0d events outstanding, expected 0", sb.size());
      sb.delete();
    end
    tick(4);
  endtask

  // Monitor: pop the next expected event on every strobe and compare.
  logic prev_sta = 1'b0, prev_frm = 1'b0, prev_par = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    int   got_kind;
    int   dt;
    if (UART_STA_RX || UART_ERR_FRM || par_pulse) begin
      chk("strobe_exclusive", int'(UART_STA_RX) + int'(UART_ERR_FRM) + int'(par_pulse), 1);
      if (UART_STA_RX)  chk("sta_width", int'(prev_sta), 0);
      if (UART_ERR_FRM) chk("frm_width", int'(prev_frm), 0);
      if (par_pulse)    chk("par_width", int'(prev_par), 0);
      got_kind = UART_STA_RX ? 0 : (UART_ERR_FRM ? 1 : 2);
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_event: kind %0d rxreg %0h, expected no event", got_kind, UART_RxREG);
      end else begin
        e = sb.pop_front();
        chk("event_kind", got_kind, e.kind);
        if (e.kind == 0) model_reg = e.data;
        chk("rxreg", int'(UART_RxREG), int'(model_reg));
        dt = cyc - e.c0;
        n_vec++;
        if (dt < EXP_LAT - 1 || dt > EXP_LAT + 1) begin
          n_miss++;
          $display("FAIL latency: got %0d cycles expected %0d +/-1", dt, EXP_LAT);
        end
      end
    end
    prev_sta = UART_STA_RX;
    prev_frm = UART_ERR_FRM;
    prev_par = par_pulse;
  end

  initial begin
    logic [7:0] d;
    int         busy_seen;
    rst = 1'b1;
    UART_RXD = 1'b1;
    tick(3);
    rst = 1'b0;
    chk("reset_rxreg", int'(UART_RxREG), 0);
    chk("reset_sta", int'(UART_STA_RX), 0);
    chk("reset_frm", int'(UART_ERR_FRM), 0);
    chk("reset_busy", int'(UART_BUSY), 0);
    tick(5);

    // Basic frame
    send_frame(8'hAA, 1'b0, 0);
    drain();

    // Back-to-back with no idle gap
    send_frame(8'h55, 1'b0, 0);
    send_frame(8'hFF, 1'b0, 0);
    drain();

    // Short low glitch on idle line
    drive_bit(1'b0, 4);
    UART_RXD = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (UART_BUSY) busy_seen = 1;
      tick(1);
    end
    chk("glitch_busy_seen", busy_seen, 1);
    chk("glitch_busy_clear", int'(UART_BUSY), 0);
    chk("glitch_rxreg", int'(UART_RxREG), int'(model_reg));
    tick(N);

    // Break: stop bit held low 40 bit-times, then a good frame
    send_frame(8'h3C, 1'b0, 40);
    drain();
    chk("break_rxreg", int'(UART_RxREG), int'(model_reg));
    send_frame(8'h81, 1'b0, 0);
    drain();

    // Reset during data bit 4 of 0xC3
    d = 8'hC3;
    drive_bit(1'b0, N);
    for (int i = 0; i < 4; i++) drive_bit(d[i], N);
    drive_bit(d[4], HALF);
    rst = 1'b1;
    UART_RXD = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reg = 8'h00;
    chk("midrst_rxreg", int'(UART_RxREG), 0);
    chk("midrst_sta", int'(UART_STA_RX), 0);
    chk("midrst_frm", int'(UART_ERR_FRM), 0);
    chk("midrst_busy", int'(UART_BUSY), 0);
    tick(2 * N);
    send_frame(8'h0F, 1'b0, 0);
    drain();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 0);
    drain();
    send_frame(8'h07, 1'b0, 0);
    drain();
    chk("parerr_rxreg", int'(UART_RxREG), 8'h07);
`endif

    // Randomized frames with random gaps, parity and occasional breaks
    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0)
        send_frame(d, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      else
        send_frame(d, (PB == 1 && $urandom_range(0, 3) == 0) ? ~(^d) : (^d), 0);
      tick(int'($urandom_range(0, 2 * N)));
    end
    drain();
    chk("final_rxreg", int'(UART_RxREG), int'(model_reg));
    chk("final_busy", int'(UART_BUSY), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the UART link; the receive-side counterpart of uart_tx.
- Frame format: 8N1 (1 start bit, 8 data bits LSB first, 1 stop bit), plus an optional even-parity bit.
- Samples UART_RXD at mid-bit using a per-bit clock counter.
- For each good frame, delivers the byte on UART_RxREG with a one-cycle valid strobe. Flags framing errors.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200). Legal values are >= 4; counter width is $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- UART_RXD  input  1  serial receive pin; asynchronous to clk; idle high
- UART_RxREG  output  8  last good received byte; holds until the next good frame
- UART_STA_RX  output  1  one-cycle pulse when UART_RxREG is updated
- UART_ERR_FRM  output  1  one-cycle pulse when the stop bit is sampled low
- UART_BUSY  output  1  high whenever the state is not IDLE

Behaviour:
- Input synchronizer
  - UART_RXD passes through 2 flops, both reset to 1. The FSM only sees the synchronized bit (rxs).
- Reset values
  - UART_RxREG=8'h00, UART_STA_RX=0, UART_ERR_FRM=0, UART_BUSY=0.
  - State=IDLE; bit counter=0; clock counter=0.
- Reset mid-frame
  - Abort the frame immediately; the partial byte is discarded and no strobe is issued.
- State IDLE
  - When rxs==0: clear the clock counter and go to START.
- State START
  - Count CLKS_PER_BIT/2 cycles, then sample rxs.
  - rxs==0: go to DATA with the clock counter cleared.
  - rxs==1: false start; return to IDLE with no output activity.
- State DATA
  - Count CLKS_PER_BIT cycles, then sample rxs into the shift register, LSB first.
  - After the 8th sample go to STOP (or PARITY when the optional feature is enabled).
- State STOP
  - Count CLKS_PER_BIT cycles, then sample rxs.
  - rxs==1: load UART_RxREG and pulse UART_STA_RX on the same clock edge; go to IDLE.
  - rxs==0: pulse UART_ERR_FRM; UART_RxREG is unchanged; go to BRK_WAIT.
- State BRK_WAIT
  - Stay until rxs==1, then go to IDLE. A held-low break line therefore yields exactly one error pulse, not a stream.
- Timing
  - Bit samples are taken (CLKS_PER_BIT/2 + k*CLKS_PER_BIT) cycles after the synchronized falling edge, k=1..9.
  - UART_STA_RX rises in the cycle after the mid-stop sample edge.
- Back-to-back frames
  - A start bit immediately after a stop bit must be received without loss. IDLE is re-entered at mid-stop, so the next falling edge is always seen.
- Output exclusivity
  - UART_STA_RX and UART_ERR_FRM are never high in the same cycle, and each is exactly 1 cycle wide.
- No read handshake
  - A consumer that misses the strobe simply loses that byte; UART_RxREG is overwritten by the next good frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN
- When defined:
  - Adds output UART_ERR_PAR (1 bit, reset 0).
  - Adds state PARITY between DATA and STOP: waits CLKS_PER_BIT cycles, then samples the parity bit. Even parity is expected (XOR of 8 data bits XOR parity bit == 0).
  - Frame ends at STOP as normal. On a parity mismatch with a good stop bit: pulse UART_ERR_PAR, suppress UART_STA_RX, leave UART_RxREG unchanged.
  - A framing error takes precedence; UART_ERR_PAR is not pulsed for that frame.
- When undefined:
  - Neither the port nor the state exists; the frame is 8N1.

Test Plan (bench uses CLKS_PER_BIT=16, clk period 10 ns):
- Drive frame 8'b1010_1010 on UART_RXD -> UART_RxREG==8'hAA and UART_STA_RX pulses exactly 1 cycle, 2+8+144 cycles (±1) after the start edge; UART_ERR_FRM stays 0.
- Back-to-back 8'h55 then 8'hFF with no idle gap -> two UART_STA_RX pulses; UART_RxREG holds 55 then FF.
- 4-cycle low glitch on an idle line -> no strobe, UART_BUSY returns to 0 within 8+2 cycles, UART_RxREG unchanged.
- Frame 8'h3C with stop bit held low for 40 bit-times -> exactly one UART_ERR_FRM pulse; UART_RxREG keeps its old value. A following valid 8'h81 frame is received correctly.
- rst asserted 1 cycle during data bit 4 of 8'hC3 -> all outputs return to reset values next cycle with no strobe. The next clean frame 8'h0F is received correctly.
- With UART_RX_PARITY_EN defined:
  - 8'h07 with parity 1 -> UART_STA_RX pulse, RxREG==07.
  - 8'h07 with parity 0 -> UART_ERR_PAR pulse, no UART_STA_RX.
